// File: rtl/spdif_tx_multi.sv
// spdif_tx_multi: IEC 60958 consumer S/PDIF transmitter with a stereo sample FIFO.
// Define SPDIF_TX_USER_CS_EN to take channel status from cs_i, captured per block.
module spdif_tx_multi #(
    parameter int         SAMPLE_W   = 24,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CS_FS_CODE = 4'b0010,
    parameter bit         CS_COPY_OK = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef SPDIF_TX_USER_CS_EN
    input  logic [191:0]                  cs_i,
`endif
    input  logic                          bit_out_en_i,
    input  logic [2*SAMPLE_W-1:0]         sample_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    output logic                          spdif_o,
    output logic                          block_start_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] PRE_B = 8'b11101000;
    localparam logic [7:0] PRE_M = 8'b11100010;
    localparam logic [7:0] PRE_W = 8'b11100100;

    function automatic logic [23:0] align(input logic [SAMPLE_W-1:0] s);
        logic [23:0] t;
        t = '0;
        t[23 -: SAMPLE_W] = s;
        return t;
    endfunction

    logic [2*SAMPLE_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [LW-1:0] r_level;
    logic [5:0]  r_hb;
    logic        r_sub, r_load, r_lvl, r_par;
    logic [7:0]  r_frame, r_pre;
    logic [23:0] r_audio, r_right;
    logic        r_uflow, r_v, r_c;

    logic [2*SAMPLE_W-1:0] w_rd_pair;
    logic [191:0] w_cs;
    logic [4:0]  w_slot;
    logic        w_push, w_pop, w_empty, w_left;
    logic        w_lvl, w_bit, w_next, w_par_upd, w_par_nxt;

    assign w_empty        = (r_level == '0);
    assign w_left         = ~r_sub;
    assign sample_ready_o = ~rst_i & (r_level != LW'(FIFO_DEPTH));
    assign w_push         = sample_valid_i & sample_ready_o;
    assign w_pop          = r_load & w_left & ~w_empty;
    assign w_rd_pair      = r_mem[r_rd];
    assign fifo_level_o   = r_level;

`ifdef SPDIF_TX_USER_CS_EN
    logic [191:0] r_cs;

    // The B frame itself already uses the freshly captured block.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_cs <= '0;
        else if (r_load && w_left && r_frame == 8'd0) r_cs <= cs_i;
    end
    assign w_cs = (w_left && r_frame == 8'd0) ? cs_i : r_cs;
`else
    function automatic logic [191:0] cs_fixed();
        logic [191:0] c;
        c = '0;
        c[2] = CS_COPY_OK;
        c[27:24] = CS_FS_CODE;
        c[32] = (SAMPLE_W > 20);
        c[35:33] = (SAMPLE_W == 24) ? 3'b101 :
                   (SAMPLE_W == 16 || SAMPLE_W == 20) ? 3'b001 : 3'b000;
        return c;
    endfunction
    localparam logic [191:0] CS_FIX = cs_fixed();
    assign w_cs = CS_FIX;
`endif

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= sample_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (!w_push && w_pop) r_level <= r_level - LW'(1);
        end
    end

    always_comb begin
        w_slot    = r_hb[5:1];
        w_lvl     = (r_hb == 6'd0) ? spdif_o : r_lvl;
        w_bit     = 1'b0;
        unique case (1'b1)
            (w_slot == 5'd31): w_bit = r_par;
            (w_slot == 5'd30): w_bit = r_c;
            (w_slot == 5'd28): w_bit = r_v;
            (w_slot >= 5'd4 && w_slot <= 5'd27): w_bit = r_audio[w_slot - 5'd4];
            default: w_bit = 1'b0;
        endcase
        // Preamble is relative to the level entering the subframe.
        if (r_hb < 6'd8)   w_next = r_pre[3'd7 - r_hb[2:0]] ^ w_lvl;
        else if (!r_hb[0]) w_next = ~spdif_o;
        else               w_next = w_bit ? ~spdif_o : spdif_o;
        w_par_upd = !r_hb[0] && w_slot >= 5'd4 && w_slot <= 5'd30;
        w_par_nxt = (w_slot == 5'd4) ? w_bit : (r_par ^ w_bit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hb <= '0;
            r_sub <= 1'b0;
            r_frame <= '0;
            r_load <= 1'b1;
            r_lvl <= 1'b0;
            r_par <= 1'b0;
            r_pre <= PRE_B;
            r_audio <= '0;
            r_right <= '0;
            r_uflow <= 1'b0;
            r_v <= 1'b0;
            r_c <= 1'b0;
            spdif_o <= 1'b0;
            block_start_o <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            block_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            if (r_load) begin
                r_load <= 1'b0;
                r_sub  <= ~r_sub;
                r_c    <= w_cs[r_frame];
                if (w_left) begin
                    r_pre         <= (r_frame == 8'd0) ? PRE_B : PRE_M;
                    block_start_o <= (r_frame == 8'd0);
                    underrun_o    <= w_empty;
                    r_uflow       <= w_empty;
                    r_v           <= w_empty;
                    r_audio <= w_empty ? '0 : align(w_rd_pair[SAMPLE_W-1:0]);
                    r_right <= w_empty ? '0 : align(w_rd_pair[2*SAMPLE_W-1:SAMPLE_W]);
                end else begin
                    r_pre   <= PRE_W;
                    r_v     <= r_uflow;
                    r_audio <= r_right;
                    r_frame <= (r_frame == 8'd191) ? 8'd0 : r_frame + 8'd1;
                end
            end
            if (bit_out_en_i) begin
                spdif_o <= w_next;
                r_hb    <= r_hb + 6'd1;
                if (r_hb == 6'd0)  r_lvl <= spdif_o;
                if (w_par_upd)     r_par <= w_par_nxt;
                if (r_hb == 6'd63) r_load <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spdif_tx_multi.sv
// Directed bench for spdif_tx_multi: decodes the BMC line per subframe
// and checks preambles, audio, V/U/C/P, pulses and FIFO level.
`timescale 1ns/1ps
module tb_spdif_tx_multi;
    localparam int SW = 24;
    localparam logic [7:0] PB = 8'b11101000;
    localparam logic [7:0] PM = 8'b11100010;
    localparam logic [7:0] PW = 8'b11100100;

    logic clk_i = 1'b0;
    logic rst_i, bit_out_en_i, sample_valid_i;
    logic [2*SW-1:0] sample_i;
    logic sample_ready_o, spdif_o, block_start_o, underrun_o;
    logic [2:0] fifo_level_o;
`ifdef SPDIF_TX_USER_CS_EN
    logic [191:0] cs_i;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int sub_k, bs_cnt, bs_first, bs_last, uf_cnt;
    logic line;
    logic [63:0] h;
    logic [191:0] cs_exp, cs_dec;

    always #5 clk_i = ~clk_i;

    spdif_tx_multi #(.SAMPLE_W(SW), .FIFO_DEPTH(4)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
`ifdef SPDIF_TX_USER_CS_EN
        .cs_i(cs_i),
`endif
        .bit_out_en_i(bit_out_en_i),
        .sample_i(sample_i),
        .sample_valid_i(sample_valid_i),
        .sample_ready_o(sample_ready_o),
        .spdif_o(spdif_o),
        .block_start_o(block_start_o),
        .underrun_o(underrun_o),
        .fifo_level_o(fifo_level_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe1(output logic b);
        @(negedge clk_i);
        if (block_start_o) begin
            bs_cnt++;
            if (bs_cnt == 1) bs_first = sub_k;
            bs_last = sub_k;
        end
        if (underrun_o) uf_cnt++;
        bit_out_en_i = 1'b1;
        @(negedge clk_i);
        bit_out_en_i = 1'b0;
        b = spdif_o;
    endtask

    task automatic get_sub();
        logic b;
        for (int i = 0; i < 64; i++) begin
            strobe1(b);
            h[i] = b;
        end
        sub_k++;
    endtask

    task automatic check_sub(input string tag, input logic [7:0] epre,
                             input logic [23:0] eaud, input logic ev,
                             input logic ec, output logic oc);
        logic [7:0] pre;
        logic [31:0] bits;
        int bad;
        for (int i = 0; i < 8; i++) pre[7-i] = h[i] ^ line;
        bad = 0;
        bits = '0;
        for (int s = 4; s < 32; s++) begin
            if (h[2*s] == h[2*s-1]) bad++;
            bits[s] = h[2*s] ^ h[2*s+1];
        end
        line = h[63];
        oc = bits[30];
        chk({tag, ".pre"}, 64'(pre), 64'(epre));
        chk({tag, ".aud"}, 64'(bits[27:4]), 64'(eaud));
        chk({tag, ".v"}, 64'(bits[28]), 64'(ev));
        chk({tag, ".u"}, 64'(bits[29]), 64'd0);
        chk({tag, ".c"}, 64'(bits[30]), 64'(ec));
        chk({tag, ".p"}, 64'(bits[31]), 64'((^eaud) ^ ev ^ ec));
        chk({tag, ".trans"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic b, oc;
        logic [7:0] epre;
        logic [23:0] lv;
        int f;
        rst_i = 1'b1;
        bit_out_en_i = 1'b0;
        sample_valid_i = 1'b0;
        sample_i = '0;
        cs_exp = '0;
        cs_dec = '0;
`ifdef SPDIF_TX_USER_CS_EN
        cs_i = '1;
        cs_exp = '1;
`else
        cs_exp[2] = 1'b1;
        cs_exp[27:24] = 4'b0010;
        cs_exp[32] = 1'b1;
        cs_exp[35:33] = 3'b101;
`endif
        repeat (3) @(negedge clk_i);
        chk("rst.spdif", 64'(spdif_o), 64'd0);
        chk("rst.bs", 64'(block_start_o), 64'd0);
        chk("rst.uf", 64'(underrun_o), 64'd0);
        chk("rst.level", 64'(fifo_level_o), 64'd0);
        chk("rst.ready", 64'(sample_ready_o), 64'd0);

        // One full block with no audio pushed: every frame underruns.
        rst_i = 1'b0;
        line = 1'b0;
        sub_k = 0; bs_cnt = 0; uf_cnt = 0; bs_first = -1; bs_last = -1;
        for (int k = 0; k < 385; k++) begin
            get_sub();
            if (k == 0) chk("t1.first_half", 64'(h[0]), 64'd1);
            f = (k / 2) % 192;
            if (k % 2 == 0) epre = (f == 0) ? PB : PM;
            else epre = PW;
            check_sub($sformatf("t1.sub%0d", k), epre, 24'h0, 1'b1, cs_exp[f], oc);
            if (k % 2 == 0 && k < 384) cs_dec[f] = oc;
        end
        chk("t1.bs_cnt", 64'(bs_cnt), 64'd2);
        chk("t1.bs_span", 64'(bs_last - bs_first), 64'd384);
        chk("t1.uf_cnt", 64'(uf_cnt), 64'd193);
        chk("t1.cs_bit2", 64'(cs_dec[2]), 64'(cs_exp[2]));
        chk("t1.cs_fs", 64'(cs_dec[27:24]), 64'(cs_exp[27:24]));
        chk("t1.cs_b32", 64'(cs_dec[32]), 64'(cs_exp[32]));
        chk("t1.cs_wl", 64'(cs_dec[35:33]), 64'(cs_exp[35:33]));
        chk("t1.cs_lo", cs_dec[63:0], cs_exp[63:0]);

        // One pushed pair lands in frame 1 after an underrun frame 0.
        @(negedge clk_i);
        rst_i = 1'b1;
        sample_i = {24'h000100, 24'h800100};
        sample_valid_i = 1'b1;
        @(negedge clk_i);
        chk("t2.rst_ready", 64'(sample_ready_o), 64'd0);
        chk("t2.rst_level", 64'(fifo_level_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        chk("t2.uf0", 64'(underrun_o), 64'd1);
        chk("t2.bs0", 64'(block_start_o), 64'd1);
        chk("t2.lvl1", 64'(fifo_level_o), 64'd1);
        line = 1'b0; uf_cnt = 0; sub_k = 0;
        get_sub(); check_sub("t2.sub0", PB, 24'h0, 1'b1, cs_exp[0], oc);
        get_sub(); check_sub("t2.sub1", PW, 24'h0, 1'b1, cs_exp[0], oc);
        get_sub(); check_sub("t2.sub2", PM, 24'h800100, 1'b0, cs_exp[1], oc);
        chk("t2.lvl0", 64'(fifo_level_o), 64'd0);
        get_sub(); check_sub("t2.sub3", PW, 24'h000100, 1'b0, cs_exp[1], oc);
        chk("t2.uf_cnt", 64'(uf_cnt), 64'd0);

        // FIFO fill with no strobes, then pops at left loads.
        @(negedge clk_i);
        rst_i = 1'b1;
        sample_valid_i = 1'b1;
        sample_i = {~24'h111111, 24'h111111};
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i);
            lv = 24'(24'h111111 * (k + 1));
            sample_i = {~lv, lv};
        end
        chk("t3.full_level", 64'(fifo_level_o), 64'd4);
        chk("t3.full_ready", 64'(sample_ready_o), 64'd0);
        line = 1'b0;
        get_sub(); check_sub("t3.sub0", PB, 24'h0, 1'b1, cs_exp[0], oc);
        get_sub(); check_sub("t3.sub1", PW, 24'h0, 1'b1, cs_exp[0], oc);
        @(negedge clk_i);
        chk("t3.pop_level", 64'(fifo_level_o), 64'd3);
        chk("t3.pop_ready", 64'(sample_ready_o), 64'd1);
        @(negedge clk_i);
        chk("t3.refill_level", 64'(fifo_level_o), 64'd4);
        chk("t3.refill_ready", 64'(sample_ready_o), 64'd0);
        sample_valid_i = 1'b0;
        get_sub(); check_sub("t3.sub2", PM, 24'h111111, 1'b0, cs_exp[1], oc);
        get_sub(); check_sub("t3.sub3", PW, 24'hEEEEEE, 1'b0, cs_exp[1], oc);
        get_sub(); check_sub("t3.sub4", PM, 24'h222222, 1'b0, cs_exp[2], oc);
        get_sub(); check_sub("t3.sub5", PW, 24'hDDDDDD, 1'b0, cs_exp[2], oc);
        sample_i = {24'h0F0F0F, 24'h777777};
        sample_valid_i = 1'b1;
        @(negedge clk_i);
        sample_valid_i = 1'b0;
        chk("t3.pushpop_level", 64'(fifo_level_o), 64'd3);
        chk("t3.pushpop_uf", 64'(underrun_o), 64'd0);
        chk("t3.pushpop_ready", 64'(sample_ready_o), 64'd1);
        get_sub(); check_sub("t3.sub6", PM, 24'h333333, 1'b0, cs_exp[3], oc);

        // Asynchronous reset inside slot 17 of the right subframe.
        for (int i = 0; i < 35; i++) strobe1(b);
        #2 rst_i = 1'b1;
        #1;
        chk("t4.spdif", 64'(spdif_o), 64'd0);
        chk("t4.level", 64'(fifo_level_o), 64'd0);
        chk("t4.ready", 64'(sample_ready_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        line = 1'b0; bs_cnt = 0; sub_k = 0;
        get_sub();
        chk("t4.first_half", 64'(h[0]), 64'd1);
        chk("t4.bs", 64'(bs_cnt), 64'd1);
        check_sub("t4.sub0", PB, 24'h0, 1'b1, cs_exp[0], oc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
